// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad to BCD encoder feeding a timer's parallel load port.
// Optional build macro KEYPAD_DIGIT_LIMIT_EN caps entry at three digits per enable window.
module keypad_encoder #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clr,
  input  logic [9:0] keys,
  input  logic       enable,
  output logic [3:0] data,
  output logic       loadn,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [3:0] DEB_LIMIT = 4'(DEB_CYCLES);

  state_t     state_reg;
  logic [9:0] sync1_reg;
  logic [9:0] ks_reg;
  logic [9:0] pattern_reg;
  logic [3:0] code_reg;
  logic [3:0] cnt_reg;
  logic [3:0] data_reg;
  logic       loadn_reg;
  logic       busy_reg;

  logic [3:0] cnt_next;
  logic       cnt_done;
  logic       ks_any;
  logic       ks_multi;
  logic       ks_one_hot;
  logic [3:0] ks_code;
  logic       ks_match;
  logic       enter_emit;
  logic       key_accept;

  // Two-flop synchronizer; every decision below looks only at ks_reg.
  always_ff @(posedge clock) begin
    if (clr) begin
      sync1_reg <= '0;
      ks_reg    <= '0;
    end else begin
      sync1_reg <= keys;
      ks_reg    <= sync1_reg;
    end
  end

  // Scan the synchronized lines: any bit, more than one bit, and index of the set bit.
  always_comb begin
    ks_any   = 1'b0;
    ks_multi = 1'b0;
    ks_code  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (ks_reg[i]) begin
        ks_multi = ks_multi | ks_any;
        ks_any   = 1'b1;
        ks_code  = 4'(i);
      end
    end
  end

  assign ks_one_hot = ks_any & ~ks_multi;
  assign ks_match   = (ks_reg == pattern_reg);

  // Saturating increment so a long hold can never wrap the counter.
  assign cnt_next = (cnt_reg == 4'hF) ? cnt_reg : cnt_reg + 4'd1;
  assign cnt_done = (cnt_next >= DEB_LIMIT);

  assign enter_emit = (state_reg == DEBOUNCE) && ks_match && enable && cnt_done;

`ifdef KEYPAD_DIGIT_LIMIT_EN
  logic [1:0] digit_reg;

  // Counts digits loaded since enable last went high; three fills m:ss.
  always_ff @(posedge clock) begin
    if (clr) begin
      digit_reg <= 2'd0;
    end else if (!enable) begin
      digit_reg <= 2'd0;
    end else if (enter_emit && (digit_reg != 2'd3)) begin
      digit_reg <= digit_reg + 2'd1;
    end
  end

  assign key_accept = (digit_reg != 2'd3);
`else
  assign key_accept = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (clr) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      code_reg    <= 4'd0;
      cnt_reg     <= 4'd0;
      data_reg    <= 4'd0;
      loadn_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      loadn_reg <= 1'b1;
      unique case (state_reg)
        IDLE: begin
          if (ks_one_hot && enable && key_accept) begin
            state_reg   <= DEBOUNCE;
            pattern_reg <= ks_reg;
            code_reg    <= ks_code;
            cnt_reg     <= 4'd1;
            busy_reg    <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!ks_match) begin
            // Key bounced, changed, or a second key joined: drop silently.
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            busy_reg  <= 1'b0;
          end else if (!enable) begin
            // Timer started mid-press; wait for release without loading.
            state_reg <= HOLD;
            cnt_reg   <= 4'd0;
            busy_reg  <= 1'b1;
          end else if (cnt_done) begin
            state_reg <= EMIT;
            cnt_reg   <= 4'd0;
            data_reg  <= code_reg;
            loadn_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        EMIT: begin
          state_reg <= HOLD;
          cnt_reg   <= 4'd0;
          busy_reg  <= 1'b1;
        end
        HOLD: begin
          if (ks_any) begin
            cnt_reg <= 4'd0;
          end else if (cnt_done) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 4'd0;
          loadn_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign data  = data_reg;
  assign loadn = loadn_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: directed press scenarios plus random key traffic.
// Build with KEYPAD_DIGIT_LIMIT_EN defined to exercise the three-digit cap.
module tb_keypad_encoder;

  localparam int DEB = 4;
`ifdef KEYPAD_DIGIT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic [9:0] keys = '0;
  logic       enable = 1'b1;
  logic [3:0] data;
  logic       loadn;
  logic       busy;

  keypad_encoder #(.DEB_CYCLES(DEB)) dut (
    .clock  (clock),
    .clr    (clr),
    .keys   (keys),
    .enable (enable),
    .data   (data),
    .loadn  (loadn),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       loadn;
    logic [3:0] data;
    logic       busy;
  } exp_t;

  typedef struct {
    int kind;   // 0 strobes since mark, 1 data now, 2 strobe offset, 3 mark, 4 drained
    int expv;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t dir_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  int base_cnt = 0;
  int base_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: the line values two edges back, and the press lifecycle
  // described as a run of identical single-key samples followed by a quiet run.
  logic [9:0] m_s1, m_s2;
  bit         m_wait_release;
  int         m_run;
  int         m_quiet;
  bit         m_strobe;
  logic [3:0] m_cap;
  logic [3:0] m_data;
  int         m_digits;

  function automatic int low_index(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input logic [9:0] k, input logic en, input logic c);
    logic [9:0] seen;
    logic [9:0] one;
    bit         emitted;
    exp_t       e;
    seen    = m_s2;
    one     = 10'd1;
    emitted = 1'b0;
    if (c) begin
      m_s1 = '0; m_s2 = '0;
      m_wait_release = 1'b0; m_run = 0; m_quiet = 0; m_strobe = 1'b0;
      m_data = 4'd0; m_digits = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = k;
      if (m_strobe) begin
        m_strobe = 1'b0;
        m_wait_release = 1'b1;
        m_quiet = 0;
      end else if (m_wait_release) begin
        m_quiet = (seen != 0) ? 0 : m_quiet + 1;
        if (m_quiet >= DEB) m_wait_release = 1'b0;
      end else if (m_run > 0) begin
        if (seen != (one << m_cap)) begin
          m_run = 0;
        end else if (!en) begin
          m_run = 0;
          m_wait_release = 1'b1;
          m_quiet = 0;
        end else begin
          m_run = m_run + 1;
          if (m_run >= DEB) begin
            m_run = 0;
            m_strobe = 1'b1;
            m_data = m_cap;
            emitted = 1'b1;
          end
        end
      end else if ($countones(seen) == 1 && en && !(LIMIT && m_digits == 3)) begin
        m_run = 1;
        m_cap = 4'(low_index(seen));
      end
      if (!en) m_digits = 0;
      else if (emitted && m_digits < 3) m_digits = m_digits + 1;
    end
    e.loadn = ~m_strobe;
    e.data  = m_data;
    e.busy  = m_strobe | m_wait_release | (m_run > 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [9:0] k, input logic en, input logic c);
    keys = k;
    enable = en;
    clr = c;
    model_edge(k, en, c);
    @(posedge clock);
    #1;
  endtask

  task automatic hold_keys(input logic [9:0] k, input logic en, input int n);
    for (int i = 0; i < n; i++) step(k, en, 1'b0);
  endtask

  task automatic mark();
    dchk_t d;
    d.kind = 3; d.expv = cyc;
    dir_q.push_back(d);
  endtask

  task automatic expect_dir(input int kind, input int v);
    dchk_t d;
    d.kind = kind; d.expv = v;
    dir_q.push_back(d);
  endtask

  task automatic reset_dut();
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: pops one expectation per clock, logs strobes, resolves directed checks.
  always @(negedge clock) begin
    exp_t  e;
    dchk_t d;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("loadn", (loadn === e.loadn) ? int'(e.loadn) : -1, int'(e.loadn));
      chk("busy", (busy === e.busy) ? int'(e.busy) : -1, int'(e.busy));
      chk("data", ($isunknown(data)) ? -1 : int'(data), int'(e.data));
    end
    if (loadn === 1'b0) begin
      strobe_cnt = strobe_cnt + 1;
      last_strobe_cyc = cyc;
      $display("strobe cycle=%0d data=%0d", cyc, data);
    end
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      case (d.kind)
        0: chk("strobe_count", strobe_cnt - base_cnt, d.expv);
        1: chk("data_now", ($isunknown(data)) ? -1 : int'(data), d.expv);
        2: chk("strobe_latency", last_strobe_cyc - base_cyc, d.expv);
        3: begin base_cnt = strobe_cnt; base_cyc = d.expv; end
        default: chk("scoreboard_drained", exp_q.size(), 0);
      endcase
    end
  end

  initial begin
    logic [9:0] one;
    logic [9:0] pat;
    logic       en;
    bit         c;
    int         r, len;
    one = 10'd1;

    // Single press of key 2, stable long enough to load once.
    reset_dut();
    mark();
    hold_keys(10'b0000000100, 1'b1, 10);
    hold_keys('0, 1'b1, 8);
    expect_dir(0, 1);
    expect_dir(1, 2);
    expect_dir(2, 2 + DEB);

    // Short bounce on key 5: nothing loads.
    reset_dut();
    mark();
    hold_keys(10'b0000100000, 1'b1, 2);
    hold_keys('0, 1'b1, 8);
    expect_dir(0, 0);
    expect_dir(1, 0);

    // Keys 1 and 5 together are ignored, then key 9 alone loads.
    reset_dut();
    mark();
    hold_keys(10'b0000100010, 1'b1, 10);
    expect_dir(0, 0);
    hold_keys(10'b1000000000, 1'b1, 10);
    hold_keys('0, 1'b1, 8);
    expect_dir(0, 1);
    expect_dir(1, 9);

    // Enable drops during key 3 debounce: no load, busy until released.
    reset_dut();
    mark();
    hold_keys(10'b0000001000, 1'b1, 3);
    hold_keys(10'b0000001000, 1'b0, 7);
    hold_keys('0, 1'b0, 8);
    hold_keys('0, 1'b1, 2);
    expect_dir(0, 0);
    expect_dir(1, 0);

    // Reset in the middle of key 7 debounce, key kept held: reload after re-debounce.
    reset_dut();
    mark();
    hold_keys(10'b0010000000, 1'b1, 4);
    step(10'b0010000000, 1'b1, 1'b1);
    expect_dir(1, 0);
    expect_dir(0, 0);
    hold_keys(10'b0010000000, 1'b1, 12);
    hold_keys('0, 1'b1, 8);
    expect_dir(0, 1);
    expect_dir(1, 7);

    // Four separate presses, then an enable gap and one more.
    reset_dut();
    mark();
    for (int d = 1; d <= 4; d++) begin
      hold_keys(one << d, 1'b1, 8);
      hold_keys('0, 1'b1, 8);
    end
    expect_dir(0, LIMIT ? 3 : 4);
    expect_dir(1, LIMIT ? 3 : 4);
    mark();
    step('0, 1'b0, 1'b0);
    hold_keys(10'b0000010000, 1'b1, 8);
    hold_keys('0, 1'b1, 8);
    expect_dir(0, 1);
    expect_dir(1, 4);

    // Random traffic: silence, single keys, key pairs, enable gaps, rare resets.
    reset_dut();
    for (int s = 0; s < 60; s++) begin
      r   = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      if (r < 3) pat = '0;
      else if (r < 8) pat = one << $urandom_range(0, 9);
      else pat = (one << $urandom_range(0, 9)) | (one << $urandom_range(0, 9));
      en = ($urandom_range(0, 5) != 0);
      c  = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < len; i++) step(pat, en, c && (i == 0));
    end
    hold_keys('0, 1'b1, 10);

    expect_dir(4, 0);
    @(negedge clock);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
